// File: rtl/dpram_pkg.sv
// Shared types and helpers for the dual-port RAM controller.
package dpram_pkg;

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  typedef enum logic {RDW_WRITE_FIRST, RDW_READ_FIRST} rdw_mode_e;

  // Number of byte lanes in a word.
  function automatic int nb(input int data_w, input int byte_w);
    return data_w / byte_w;
  endfunction

endpackage

// File: rtl/dual_port_ram_ctrl_if.sv
// Request/response bundle for both RAM ports. master = requester, slave = RAM.
interface dual_port_ram_ctrl_if
  import dpram_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int BYTE_W = 8,
  parameter int ADDR_W = 10
);
  localparam int NB = nb(DATA_W, BYTE_W);

  logic              ena, enb;
  logic              rsta, rstb;
  logic [NB-1:0]     wea, web;
  logic [ADDR_W-1:0] addra, addrb;
  logic [DATA_W-1:0] dina, dinb;
  logic [DATA_W-1:0] douta, doutb;
  logic              collision;
  logic              init_done;

  modport master (
    output ena, enb, rsta, rstb, wea, web, addra, addrb, dina, dinb,
    input  douta, doutb, collision, init_done
  );

  modport slave (
    input  ena, enb, rsta, rstb, wea, web, addra, addrb, dina, dinb,
    output douta, doutb, collision, init_done
  );
endinterface

// File: rtl/dpram_core.sv
// Storage array with two byte-enabled write ports and two registered read
// ports. Reads always return the pre-write (old) word. On a shared address,
// port A's bytes override port B's.
module dpram_core
  import dpram_pkg::*;
#(
  parameter int  DATA_W = 32,
  parameter int  BYTE_W = 8,
  parameter int  ADDR_W = 10,
  localparam int NB     = nb(DATA_W, BYTE_W),
  localparam int DEPTH  = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [NB-1:0]     we_a,
  input  logic [NB-1:0]     we_b,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] din_a,
  input  logic [DATA_W-1:0] din_b,
  input  logic              re_a,
  input  logic              re_b,
  input  logic              clr_a,
  input  logic              clr_b,
  output logic [DATA_W-1:0] q_a,
  output logic [DATA_W-1:0] q_b
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Byte writes; B is applied first so A's later assignment wins per byte.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NB; i++)
      if (we_b[i]) mem[addr_b][i*BYTE_W +: BYTE_W] <= din_b[i*BYTE_W +: BYTE_W];
    for (int i = 0; i < NB; i++)
      if (we_a[i]) mem[addr_a][i*BYTE_W +: BYTE_W] <= din_a[i*BYTE_W +: BYTE_W];
  end

  // Port A read register: clear beats read, holds when idle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)      q_a <= '0;
    else if (clr_a) q_a <= '0;
    else if (re_a)  q_a <= mem[addr_a];
  end

  // Port B read register: clear beats read, holds when idle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)      q_b <= '0;
    else if (clr_b) q_b <= '0;
    else if (re_b)  q_b <= mem[addr_b];
  end

endmodule

// File: rtl/dual_port_ram_ctrl.sv
// True dual-port RAM controller: post-reset scrub FSM, collision flag,
// same-port read-during-write selection and optional output pipeline.
// Optional feature macro: DPRAM_OUTREG_EN (adds a second output stage).
module dual_port_ram_ctrl
  import dpram_pkg::*;
#(
  parameter int              DATA_W   = 32,
  parameter int              BYTE_W   = 8,
  parameter int              ADDR_W   = 10,
  parameter int              RDW_MODE = 0,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input logic                 clk,
  input logic                 rstn,
  dual_port_ram_ctrl_if.slave bus
);

  localparam int        NB    = nb(DATA_W, BYTE_W);
  localparam int        DEPTH = 2**ADDR_W;
  localparam rdw_mode_e RDW   = (RDW_MODE == 1) ? RDW_READ_FIRST : RDW_WRITE_FIRST;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              run;

  logic [NB-1:0]     we_a, we_b;
  logic [ADDR_W-1:0] addr_a, addr_b;
  logic [DATA_W-1:0] din_a, din_b;
  logic              re_a, re_b, clr_a, clr_b;
  logic [DATA_W-1:0] q_a, q_b;

  // FSM state and scrub counter.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state plus port mux: scrub owns write port A until the last word is written.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    run     = 1'b0;
    we_a    = '0;
    we_b    = '0;
    addr_a  = bus.addra;
    addr_b  = bus.addrb;
    din_a   = bus.dina;
    din_b   = bus.dinb;
    re_a    = 1'b0;
    re_b    = 1'b0;
    clr_a   = 1'b0;
    clr_b   = 1'b0;
    if (state_q == ST_INIT) begin
      we_a   = '1;
      addr_a = cnt_q;
      din_a  = INIT_VAL;
      cnt_d  = cnt_q + ADDR_W'(1);
      if (cnt_q == ADDR_W'(DEPTH-1)) state_d = ST_RUN;
    end else begin
      run   = 1'b1;
      we_a  = bus.ena ? bus.wea : '0;
      we_b  = bus.enb ? bus.web : '0;
      re_a  = bus.ena;
      re_b  = bus.enb;
      clr_a = bus.rsta;
      clr_b = bus.rstb;
    end
  end

  dpram_core #(
    .DATA_W (DATA_W),
    .BYTE_W (BYTE_W),
    .ADDR_W (ADDR_W)
  ) u_core (
    .clk    (clk),
    .rstn   (rstn),
    .we_a   (we_a),
    .we_b   (we_b),
    .addr_a (addr_a),
    .addr_b (addr_b),
    .din_a  (din_a),
    .din_b  (din_b),
    .re_a   (re_a),
    .re_b   (re_b),
    .clr_a  (clr_a),
    .clr_b  (clr_b),
    .q_a    (q_a),
    .q_b    (q_b)
  );

  // Per-port bit masks of the bytes being written this cycle.
  logic [DATA_W-1:0] bm_a, bm_b;
  for (genvar g = 0; g < NB; g++) begin : g_bm
    assign bm_a[g*BYTE_W +: BYTE_W] = {BYTE_W{we_a[g]}};
    assign bm_b[g*BYTE_W +: BYTE_W] = {BYTE_W{we_b[g]}};
  end

  // Write-first: remember the port's own written bytes and overlay them on
  // the old word from the core. The other port's write is never overlaid,
  // so cross-port reads see old data. Read-first keeps the mask empty.
  logic [DATA_W-1:0] msk_a_q, msk_b_q, wd_a_q, wd_b_q;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      msk_a_q <= '0; wd_a_q <= '0;
      msk_b_q <= '0; wd_b_q <= '0;
    end else begin
      if (clr_a)     msk_a_q <= '0;
      else if (re_a) begin
        msk_a_q <= (RDW == RDW_WRITE_FIRST) ? bm_a : '0;
        wd_a_q  <= din_a;
      end
      if (clr_b)     msk_b_q <= '0;
      else if (re_b) begin
        msk_b_q <= (RDW == RDW_WRITE_FIRST) ? bm_b : '0;
        wd_b_q  <= din_b;
      end
    end
  end

  logic [DATA_W-1:0] rd_a, rd_b;
  assign rd_a = (q_a & ~msk_a_q) | (wd_a_q & msk_a_q);
  assign rd_b = (q_b & ~msk_b_q) | (wd_b_q & msk_b_q);

  // Collision flag, registered so it lines up with the read data.
  logic col_now, col_q;
  assign col_now = bus.ena & bus.enb & (bus.addra == bus.addrb) & ((|bus.wea) | (|bus.web));

  // Collision register: cleared by either port clear, updated on any access.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                      col_q <= 1'b0;
    else if (run) begin
      if (clr_a | clr_b)            col_q <= 1'b0;
      else if (bus.ena | bus.enb)   col_q <= col_now;
    end
  end

  assign bus.init_done = run;

`ifdef DPRAM_OUTREG_EN
  logic [1:0]        vld_pipe;  // previous-cycle read enables {B, A}
  logic [DATA_W-1:0] out_a_q, out_b_q;
  logic              out_col_q;

  // Second output stage, advancing only behind an enabled read.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_pipe  <= '0;
      out_a_q   <= '0;
      out_b_q   <= '0;
      out_col_q <= 1'b0;
    end else begin
      vld_pipe <= {re_b, re_a};
      if (clr_a)            out_a_q <= '0;
      else if (vld_pipe[0]) out_a_q <= rd_a;
      if (clr_b)            out_b_q <= '0;
      else if (vld_pipe[1]) out_b_q <= rd_b;
      if (clr_a | clr_b)    out_col_q <= 1'b0;
      else if (|vld_pipe)   out_col_q <= col_q;
    end
  end

  assign bus.douta     = out_a_q;
  assign bus.doutb     = out_b_q;
  assign bus.collision = out_col_q;
`else
  assign bus.douta     = rd_a;
  assign bus.doutb     = rd_b;
  assign bus.collision = col_q;
`endif

endmodule

// File: tb/tb_dual_port_ram_ctrl.sv
// Self-checking bench for dual_port_ram_ctrl (DATA_W=32, ADDR_W=4).
// A word-level model predicts douta/doutb/collision/init_done every cycle.
module tb_dual_port_ram_ctrl;

  localparam int DATA_W   = 32;
  localparam int BYTE_W   = 8;
  localparam int ADDR_W   = 4;
  localparam int DEPTH    = 16;
  localparam int RDW_MODE = 0;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  dual_port_ram_ctrl_if #(.DATA_W(DATA_W), .BYTE_W(BYTE_W), .ADDR_W(ADDR_W)) bus ();

  dual_port_ram_ctrl #(
    .DATA_W   (DATA_W),
    .BYTE_W   (BYTE_W),
    .ADDR_W   (ADDR_W),
    .RDW_MODE (RDW_MODE),
    .INIT_VAL ('0)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  bit chk_on = 0;

  // model state
  logic [31:0] m_mem [DEPTH];
  bit          m_run;
  int          m_cnt;
  logic [31:0] m_da, m_db;
  logic        m_col;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [31:0] bmerge(input logic [31:0] old, input logic [31:0] din,
                                         input logic [3:0] we);
    logic [31:0] r = old;
    for (int i = 0; i < 4; i++) if (we[i]) r[i*8 +: 8] = din[i*8 +: 8];
    return r;
  endfunction

  task automatic model_reset();
    m_run = 0; m_cnt = 0; m_da = '0; m_db = '0; m_col = 1'b0;
  endtask

  // One rising edge of the reference behaviour.
  task automatic model_edge();
    logic [31:0] olda, oldb;
    if (!rstn) begin model_reset(); return; end
    if (!m_run) begin
      m_mem[m_cnt] = '0;
      m_cnt++;
      if (m_cnt == DEPTH) m_run = 1;
      return;
    end
    olda = m_mem[bus.addra];
    oldb = m_mem[bus.addrb];
    if (bus.rsta) m_da = '0;
    else if (bus.ena) m_da = (RDW_MODE == 0) ? bmerge(olda, bus.dina, bus.wea) : olda;
    if (bus.rstb) m_db = '0;
    else if (bus.enb) m_db = (RDW_MODE == 0) ? bmerge(oldb, bus.dinb, bus.web) : oldb;
    if (bus.rsta || bus.rstb) m_col = 1'b0;
    else if (bus.ena || bus.enb)
      m_col = bus.ena && bus.enb && (bus.addra == bus.addrb) && (bus.wea != 0 || bus.web != 0);
    // A goes last so it owns any byte both ports write
    if (bus.enb) m_mem[bus.addrb] = bmerge(m_mem[bus.addrb], bus.dinb, bus.web);
    if (bus.ena) m_mem[bus.addra] = bmerge(m_mem[bus.addra], bus.dina, bus.wea);
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      check("douta", bus.douta, m_da);
      check("doutb", bus.doutb, m_db);
      check("collision", 32'(bus.collision), 32'(m_col));
      check("init_done", 32'(bus.init_done), 32'(m_run));
    end
  end

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic op(input logic ea, input logic [3:0] wa, input logic [3:0] aa, input logic [31:0] da,
                    input logic eb, input logic [3:0] wb, input logic [3:0] ab, input logic [31:0] db);
    bus.ena = ea; bus.wea = wa; bus.addra = aa; bus.dina = da;
    bus.enb = eb; bus.web = wb; bus.addrb = ab; bus.dinb = db;
    step();
  endtask

  initial begin
    bus.ena = 0; bus.enb = 0; bus.rsta = 0; bus.rstb = 0;
    bus.wea = '0; bus.web = '0; bus.addra = '0; bus.addrb = '0;
    bus.dina = '0; bus.dinb = '0;
    rstn = 1'b1;
    #1 rstn = 1'b0;
    model_reset();
    #1;
    check("reset douta", bus.douta, 32'h0);
    check("reset init_done", 32'(bus.init_done), 32'h0);
    chk_on = 1;
    repeat (2) step();

    // scrub with requests that must be ignored
    bus.ena = 1; bus.wea = 4'hF; bus.dina = 32'h12345678;
    rstn = 1'b1;
    repeat (15) step();
    check("init_done before 16th edge", 32'(bus.init_done), 32'h0);
    step();
    check("init_done at 16th edge", 32'(bus.init_done), 32'h1);
    for (int a = 0; a < DEPTH; a++) begin
      op(1, 4'h0, 4'(a), 32'h0, 1, 4'h0, 4'(15 - a), 32'h0);
      check("scrubbed word", bus.douta, 32'h0);
    end

    // cross-port read
    op(1, 4'hF, 4'd3, 32'hDEADBEEF, 0, 4'h0, 4'd0, 32'h0);
    op(0, 4'h0, 4'd0, 32'h0, 1, 4'h0, 4'd3, 32'h0);
    check("cross-port read", bus.doutb, 32'hDEADBEEF);

    // byte enables
    op(1, 4'hF, 4'd9, 32'h11223344, 0, 4'h0, 4'd0, 32'h0);
    op(1, 4'b0101, 4'd9, 32'hAABBCCDD, 0, 4'h0, 4'd0, 32'h0);
    check("byte-enable write-first", bus.douta, 32'h11BB33DD);
    op(0, 4'h0, 4'd0, 32'h0, 1, 4'h0, 4'd9, 32'h0);
    check("byte-enable readback", bus.doutb, 32'h11BB33DD);

    // write-write collision
    op(1, 4'b0001, 4'd5, 32'h000000AA, 1, 4'b0011, 4'd5, 32'h0000BBCC);
    check("collision flag", 32'(bus.collision), 32'h1);
    op(1, 4'h0, 4'd5, 32'h0, 1, 4'h0, 4'd5, 32'h0);
    check("collision clears", 32'(bus.collision), 32'h0);
    check("collision merge", bus.douta, 32'h0000BBAA);

    // same-port read-during-write
    op(1, 4'hF, 4'd7, 32'h9, 0, 4'h0, 4'd0, 32'h0);
    op(1, 4'hF, 4'd7, 32'h5, 0, 4'h0, 4'd0, 32'h0);
    check("read-during-write", bus.douta, (RDW_MODE == 1) ? 32'h9 : 32'h5);

    // output clear
    op(1, 4'h0, 4'd7, 32'h0, 0, 4'h0, 4'd0, 32'h0);
    bus.rsta = 1;
    op(1, 4'h0, 4'd7, 32'h0, 0, 4'h0, 4'd0, 32'h0);
    check("rsta clears douta", bus.douta, 32'h0);
    bus.rsta = 0;
    op(0, 4'h0, 4'd7, 32'h0, 0, 4'h0, 4'd0, 32'h0);
    check("douta holds after clear", bus.douta, 32'h0);

    // randomized traffic, addresses biased toward collisions
    for (int n = 0; n < 400; n++) begin
      bus.rsta = ($urandom_range(15) == 0);
      bus.rstb = ($urandom_range(15) == 0);
      op($urandom_range(3) != 0, ($urandom_range(1) != 0) ? 4'($urandom) : 4'h0,
         ($urandom_range(1) != 0) ? 4'($urandom_range(3)) : 4'($urandom), $urandom,
         $urandom_range(3) != 0, ($urandom_range(1) != 0) ? 4'($urandom) : 4'h0,
         ($urandom_range(1) != 0) ? 4'($urandom_range(3)) : 4'($urandom), $urandom);
    end
    bus.rsta = 0; bus.rstb = 0;

    // reset mid-run
    op(1, 4'hF, 4'd2, 32'hCAFE0002, 0, 4'h0, 4'd0, 32'h0);
    check("pre-reset douta", bus.douta, 32'hCAFE0002);
    #2 rstn = 1'b0;
    model_reset();
    #1;
    check("async reset douta", bus.douta, 32'h0);
    check("async reset init_done", 32'(bus.init_done), 32'h0);
    op(0, 4'h0, 4'd0, 32'h0, 0, 4'h0, 4'd0, 32'h0);
    step();
    rstn = 1'b1;
    repeat (DEPTH) step();
    check("re-scrub done", 32'(bus.init_done), 32'h1);
    op(1, 4'h0, 4'd2, 32'h0, 0, 4'h0, 4'd0, 32'h0);
    check("addr 2 re-scrubbed", bus.douta, 32'h0);

    chk_on = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
